// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states and the
// address/wdata mux select values consumed by the existing mux instances.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GNT_DM = 2'd1;
  localparam logic [1:0] ST_GNT_IF = 2'd2;

  localparam logic SEL_DATA  = 1'b1;
  localparam logic SEL_FETCH = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GNT_DM = ST_GNT_DM,
    GNT_IF = ST_GNT_IF
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported instruction/data memory between IF fetch and
// MEM load/store: data first, with a streak limit so fetch always progresses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT       = 2,
  parameter int MAX_DM_STREAK = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic dm_we,
  output logic mem_sel,
  output logic mem_en,
  output logic mem_we,
  output logic if_ack,
  output logic dm_ack,
  output logic if_stall,
  output logic dm_stall
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DM_STREAK);

  arb_state_e       state, state_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
  logic [STK_W-1:0] streak, streak_nxt;
  logic             last_cyc;
  logic             arb_en;
  logic             pick_dm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      streak  <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      streak  <= streak_nxt;
    end
  end

  // Re-arbitrating in the final grant cycle lets grants run back to back.
  always_comb begin
    last_cyc    = (state != IDLE) && (lat_cnt == LAT_LAST);
    arb_en      = (state == IDLE) || last_cyc;
    pick_dm     = dm_req & ~(if_req & (streak == STK_MAX));
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    streak_nxt  = streak;
    if (arb_en) begin
      lat_cnt_nxt = '0;
      if (pick_dm) begin
        state_nxt = GNT_DM;
        if (!if_req)
          streak_nxt = '0;
        else if (streak != STK_MAX)
          streak_nxt = streak + 1'b1;
      end else if (if_req) begin
        state_nxt  = GNT_IF;
        streak_nxt = '0;
      end else begin
        state_nxt = IDLE;
      end
    end else begin
      lat_cnt_nxt = lat_cnt + 1'b1;
    end
  end

  assign mem_sel  = (state == GNT_DM) ? SEL_DATA : SEL_FETCH;
  assign mem_en   = (state != IDLE);
  assign mem_we   = (state == GNT_DM) & dm_we;
  assign if_ack   = (state == GNT_IF) && (lat_cnt == LAT_LAST);
  assign dm_ack   = (state == GNT_DM) && (lat_cnt == LAT_LAST);
  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus hand-written
// sequences for collision ordering, reset mid-grant and single-cycle latency.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst, if_req, dm_req, dm_we;
  logic mem_sel, mem_en, mem_we, if_ack, dm_ack, if_stall, dm_stall;
  logic if1_req, dm1_req, dm1_we;
  logic mem1_sel, mem1_en, mem1_we, if1_ack, dm1_ack, if1_stall, dm1_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2), .MAX_DM_STREAK(3)) u0 (
    .clk(clk), .rst(rst), .if_req(if_req), .dm_req(dm_req), .dm_we(dm_we),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we),
    .if_ack(if_ack), .dm_ack(dm_ack), .if_stall(if_stall), .dm_stall(dm_stall)
  );

  mem_port_arbiter #(.MEM_LAT(1), .MAX_DM_STREAK(3)) u1 (
    .clk(clk), .rst(rst), .if_req(if1_req), .dm_req(dm1_req), .dm_we(dm1_we),
    .mem_sel(mem1_sel), .mem_en(mem1_en), .mem_we(mem1_we),
    .if_ack(if1_ack), .dm_ack(dm1_ack), .if_stall(if1_stall), .dm_stall(dm1_stall)
  );

  // expected bits: {mem_sel, mem_en, mem_we, if_ack, dm_ack, if_stall, dm_stall}
  typedef struct packed {
    logic       rst;
    logic       if_req;
    logic       dm_req;
    logic       dm_we;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic r, logic i, logic d, logic w, logic [6:0] e);
    vec_t v;
    v.rst = r; v.if_req = i; v.dm_req = d; v.dm_we = w; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // dm_we must not change inside a data grant
  logic mon_sel = 1'b0, mon_ack = 1'b0, mon_we = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      mon_sel = 1'b0;
    end else begin
      if (mem_sel && mon_sel && !mon_ack && (dm_we !== mon_we)) begin
        errors++;
        $display("FAIL dm_we_stable: got %0b expected %0b", dm_we, mon_we);
      end
      mon_sel = mem_sel;
      mon_ack = dm_ack;
      mon_we  = dm_we;
    end
  end

  function automatic logic [6:0] outs0();
    return {mem_sel, mem_en, mem_we, if_ack, dm_ack, if_stall, dm_stall};
  endfunction

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if1_req = 1'b0; dm1_req = 1'b0; dm1_we = 1'b0;

    vecs[0]  = mk(1, 0, 0, 0, 7'b0000000);
    vecs[1]  = mk(1, 0, 1, 0, 7'b0000001);
    vecs[2]  = mk(0, 1, 0, 0, 7'b0000010);
    vecs[3]  = mk(0, 1, 0, 0, 7'b0100010);
    vecs[4]  = mk(0, 0, 0, 0, 7'b0101000);
    vecs[5]  = mk(0, 0, 0, 0, 7'b0000000);
    vecs[6]  = mk(0, 0, 1, 1, 7'b0000001);
    vecs[7]  = mk(0, 0, 1, 1, 7'b1110001);
    vecs[8]  = mk(0, 0, 0, 1, 7'b1110100);
    vecs[9]  = mk(0, 0, 0, 0, 7'b0000000);
    vecs[10] = mk(0, 0, 1, 0, 7'b0000001);
    vecs[11] = mk(0, 0, 1, 0, 7'b1100001);
    vecs[12] = mk(0, 0, 0, 0, 7'b1100100);
    vecs[13] = mk(0, 0, 0, 0, 7'b0000000);
    vecs[14] = mk(0, 1, 0, 0, 7'b0000010);
    vecs[15] = mk(0, 1, 1, 0, 7'b0100011);
    vecs[16] = mk(0, 0, 1, 0, 7'b0101001);
    vecs[17] = mk(0, 0, 1, 0, 7'b1100001);
    vecs[18] = mk(0, 0, 0, 0, 7'b1100100);
    vecs[19] = mk(0, 0, 0, 0, 7'b0000000);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; if_req = vecs[i].if_req;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
      #1;
      chk($sformatf("vec%0d", i), 32'(outs0()), 32'(vecs[i].exp));
    end

    // reset in the first cycle of a data grant
    @(negedge clk); dm_req = 1'b1; dm_we = 1'b1; #1;
    chk("rstmid_idle_en", 32'(mem_en), 32'd0);
    @(negedge clk); #1;
    chk("rstmid_grant", 32'({mem_sel, mem_en, dm_ack}), 32'b110);
    #2 rst = 1'b1; #1;
    chk("rstmid_async", 32'(outs0()), 32'b0000001);
    @(negedge clk); rst = 1'b0; #1;
    chk("rstmid_after", 32'(outs0()), 32'b0000001);
    @(negedge clk); #1;
    chk("rstmid_regrant", 32'(outs0()), 32'b1110001);
    @(negedge clk); dm_req = 1'b0; #1;
    chk("rstmid_ack", 32'(outs0()), 32'b1110100);
    @(negedge clk); dm_we = 1'b0; #1;
    chk("rstmid_idle", 32'(outs0()), 32'b0000000);

    // continuous collision: DM,DM,DM,IF repeating, 2 cycles each
    @(negedge clk); if_req = 1'b1; dm_req = 1'b1; #1;
    chk("coll_start", 32'(mem_en), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      int  g;
      logic ph, edm;
      @(negedge clk); #1;
      g   = (k - 1) / 2;
      ph  = 1'((k - 1) % 2);
      edm = ((g % 4) != 3);
      chk($sformatf("coll%0d", k), 32'({mem_sel, mem_en, if_ack, dm_ack}),
          32'({edm, 1'b1, ~edm & ph, edm & ph}));
    end
    // request dropped mid-grant: grant still completes with an ack
    @(negedge clk); if_req = 1'b0; dm_req = 1'b0; #1;
    chk("drop_grant", 32'(outs0()), 32'b1100000);
    @(negedge clk); #1;
    chk("drop_ack", 32'(outs0()), 32'b1100100);
    @(negedge clk); #1;
    chk("drop_idle", 32'(outs0()), 32'b0000000);

    // single-cycle latency: back-to-back data grants
    @(negedge clk); dm1_req = 1'b1; #1;
    chk("lat1_c0", 32'({mem1_en, dm1_ack}), 32'b00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("lat1_c%0d", k), 32'({mem1_sel, mem1_en, dm1_ack, dm1_stall}), 32'b1110);
    end
    @(negedge clk); dm1_req = 1'b0; #1;
    chk("lat1_c4", 32'({mem1_sel, mem1_en, dm1_ack}), 32'b111);
    chk("lat1_streak", 32'(u1.streak), 32'd0);
    @(negedge clk); #1;
    chk("lat1_c5", 32'({mem1_en, dm1_ack}), 32'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
